// File: rtl/rds_block_sync.sv
// RDS block synchroniser: slides a 26-bit window over the demodulated bit stream,
// locks onto valid offset words and then tracks the A/B/C(C')/D block sequence.
module rds_block_sync #(
  parameter int MAX_BAD = 4
) (
  input  logic        clk_25m,
  input  logic        reset_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] block_data,
  output logic [2:0]  block_id,
  output logic        block_valid,
  output logic        block_err,
  output logic        synced
);

  localparam int BAD_W = $clog2(MAX_BAD + 1);
  localparam logic [9:0] POLY = 10'h1B9;
  localparam logic [2:0] ID_A  = 3'd0;
  localparam logic [2:0] ID_B  = 3'd1;
  localparam logic [2:0] ID_C  = 3'd2;
  localparam logic [2:0] ID_CP = 3'd3;
  localparam logic [2:0] ID_D  = 3'd4;

  typedef enum logic {SEARCH, SYNC} state_t;

  state_t             state_q, state_d;
  logic [25:0]        window_q, window_d;
  logic [4:0]         fill_q, fill_d;
  logic [4:0]         bitcnt_q, bitcnt_d;
  logic [BAD_W-1:0]   bad_q, bad_d;
  logic [2:0]         expected_q, expected_d;
  logic [15:0]        data_q, data_d;
  logic [2:0]         id_q, id_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [25:0]        windowNext;
  logic [9:0]         offset;
  logic [3:0]         decoded;
  logic               hit;
  logic [2:0]         hitId;
  logic               expectedHit;

  // Syndrome of the whole window: CRC of the data part XORed with the received check bits.
  function automatic logic [9:0] calcOffset(input logic [25:0] w);
    logic [9:0] r;
    logic       fb;
    r = '0;
    for (int i = 25; i >= 10; i--) begin
      fb = w[i] ^ r[9];
      r  = {r[8:0], 1'b0} ^ (fb ? POLY : 10'h000);
    end
    return r ^ w[9:0];
  endfunction

  function automatic logic [3:0] offsetToId(input logic [9:0] off);
    logic [3:0] res;
    case (off)
      10'h0FC: res = {1'b1, ID_A};
      10'h198: res = {1'b1, ID_B};
      10'h168: res = {1'b1, ID_C};
      10'h350: res = {1'b1, ID_CP};
      10'h1B4: res = {1'b1, ID_D};
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] successor(input logic [2:0] id);
    logic [2:0] res;
    case (id)
      ID_A:        res = ID_B;
      ID_B:        res = ID_C;
      ID_C, ID_CP: res = ID_D;
      default:     res = ID_A;
    endcase
    return res;
  endfunction

  assign windowNext  = {window_q[24:0], bit_in};
  assign offset      = calcOffset(windowNext);
  assign decoded     = offsetToId(offset);
  assign hit         = decoded[3];
  assign hitId       = decoded[2:0];
  // An expected C slot also accepts C', since B may be followed by either.
  assign expectedHit = hit && ((hitId == expected_q) ||
                               ((expected_q == ID_C) && (hitId == ID_CP)));

  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    fill_d     = fill_q;
    bitcnt_d   = bitcnt_q;
    bad_d      = bad_q;
    expected_d = expected_q;
    data_d     = data_q;
    id_d       = id_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (bit_valid) begin
      window_d = windowNext;
      fill_d   = (fill_q == 5'd26) ? 5'd26 : fill_q + 5'd1;
      case (state_q)
        SEARCH: begin
          if ((fill_d == 5'd26) && hit) begin
            state_d    = SYNC;
            expected_d = successor(hitId);
            bitcnt_d   = '0;
            bad_d      = '0;
            valid_d    = 1'b1;
            data_d     = windowNext[25:10];
            id_d       = hitId;
          end
        end
        default: begin
          if (bitcnt_q == 5'd25) begin
            bitcnt_d   = '0;
            expected_d = successor(expected_q);
            if (expectedHit) begin
              valid_d = 1'b1;
              data_d  = windowNext[25:10];
              id_d    = hitId;
              bad_d   = '0;
            end else begin
              err_d = 1'b1;
              // Too many misses in a row: drop lock and demand a fresh 26-bit window.
              if (bad_q == BAD_W'(MAX_BAD - 1)) begin
                state_d = SEARCH;
                fill_d  = '0;
                bad_d   = '0;
              end else begin
                bad_d = bad_q + 1'b1;
              end
            end
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_25m or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SEARCH;
      window_q   <= '0;
      fill_q     <= '0;
      bitcnt_q   <= '0;
      bad_q      <= '0;
      expected_q <= ID_A;
      data_q     <= '0;
      id_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      fill_q     <= fill_d;
      bitcnt_q   <= bitcnt_d;
      bad_q      <= bad_d;
      expected_q <= expected_d;
      data_q     <= data_d;
      id_q       <= id_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign block_data  = data_q;
  assign block_id    = id_q;
  assign block_valid = valid_q;
  assign block_err   = err_q;
  assign synced      = (state_q == SYNC);

endmodule

// File: tb/tb_rds_block_sync.sv
// Directed bench for rds_block_sync: acquisition, full group, slip search,
// loss of sync, single-error tolerance and mid-block reset.
module tb_rds_block_sync;

  logic        clk_25m = 1'b0;
  logic        reset_n = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic [15:0] block_data;
  logic [2:0]  block_id;
  logic        block_valid;
  logic        block_err;
  logic        synced;

  int checks = 0;
  int errors = 0;
  int validPulses = 0;
  int errPulses = 0;
  int bothPulses = 0;
  int baseValid;
  int baseErr;

  rds_block_sync #(.MAX_BAD(4)) dut (
    .clk_25m(clk_25m),
    .reset_n(reset_n),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .block_data(block_data),
    .block_id(block_id),
    .block_valid(block_valid),
    .block_err(block_err),
    .synced(synced)
  );

  always #5 clk_25m = ~clk_25m;

  // Pulse counters sampled on the rising edge, i.e. the value held over the previous cycle.
  always @(posedge clk_25m) begin
    if (block_valid) validPulses++;
    if (block_err) errPulses++;
    if (block_valid && block_err) bothPulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sendBits(input logic [25:0] word, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk_25m);
      bit_in = word[i];
      bit_valid = 1'b1;
      if (i != 0) begin
        repeat (gap) begin
          @(negedge clk_25m);
          bit_valid = 1'b0;
        end
      end
    end
    @(negedge clk_25m);
    bit_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] data, input logic [9:0] check, input int gap);
    sendBits({data, check}, 26, gap);
  endtask

  task automatic checkBlock(input string tag, input logic valid, input logic err,
                            input logic [2:0] id, input logic [15:0] data, input logic sync);
    checkOutput({tag, ".valid"}, 32'(block_valid), 32'(valid));
    checkOutput({tag, ".err"}, 32'(block_err), 32'(err));
    checkOutput({tag, ".id"}, 32'(block_id), 32'(id));
    checkOutput({tag, ".data"}, 32'(block_data), 32'(data));
    checkOutput({tag, ".synced"}, 32'(synced), 32'(sync));
  endtask

  task automatic pulseReset();
    #2 reset_n = 1'b0;
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] starting");
    pulseReset();
    checkBlock("reset", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk_25m);
    reset_n = 1'b1;

    // Acquire on block A with back-to-back strobes
    applyStimulus(16'h0000, 10'h0FC, 0);
    checkBlock("acqA", 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
    @(negedge clk_25m);
    checkOutput("acqA.onecycle", 32'(block_valid), 32'd0);

    // Rest of the group: B, C', D
    baseErr = errPulses;
    applyStimulus(16'h0001, 10'h021, 1);
    checkBlock("grpB", 1'b1, 1'b0, 3'd1, 16'h0001, 1'b1);
    applyStimulus(16'h0000, 10'h350, 2);
    checkBlock("grpCp", 1'b1, 1'b0, 3'd3, 16'h0000, 1'b1);
    applyStimulus(16'h0001, 10'h00D, 0);
    checkBlock("grpD", 1'b1, 1'b0, 3'd4, 16'h0001, 1'b1);
    @(negedge clk_25m);
    checkOutput("grp.noerr", 32'(errPulses - baseErr), 32'd0);

    // Loss of sync after four consecutive bad blocks
    baseErr = errPulses;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(16'h0001, 10'h000, 0);
      checkBlock("lossHold", 1'b0, 1'b1, 3'd4, 16'h0001, 1'b1);
    end
    applyStimulus(16'h0001, 10'h000, 0);
    checkBlock("lossDrop", 1'b0, 1'b1, 3'd4, 16'h0001, 1'b0);
    @(negedge clk_25m);
    checkOutput("loss.errcount", 32'(errPulses - baseErr), 32'd4);

    // Re-acquire, then a single corrupted block between good ones
    applyStimulus(16'h0000, 10'h0FC, 1);
    checkBlock("tolA", 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
    applyStimulus(16'h0001, 10'h021, 0);
    checkBlock("tolB", 1'b1, 1'b0, 3'd1, 16'h0001, 1'b1);
    applyStimulus(16'h0000, 10'h351, 0);
    checkBlock("tolBad", 1'b0, 1'b1, 3'd1, 16'h0001, 1'b1);
    applyStimulus(16'h0001, 10'h00D, 0);
    checkBlock("tolD", 1'b1, 1'b0, 3'd4, 16'h0001, 1'b1);

    // Slip search: seven stray bits ahead of an A block, no false lock on the way
    pulseReset();
    @(negedge clk_25m);
    reset_n = 1'b1;
    baseValid = validPulses;
    sendBits(26'b1000001, 7, 0);
    applyStimulus(16'h0001, 10'h145, 0);
    checkBlock("slipA", 1'b1, 1'b0, 3'd0, 16'h0001, 1'b1);
    @(negedge clk_25m);
    checkOutput("slip.pulsecount", 32'(validPulses - baseValid), 32'd1);

    // Reset after 13 bits of a B block
    sendBits(26'({16'h0001, 10'h021} >> 13), 13, 0);
    pulseReset();
    checkBlock("midReset", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk_25m);
    baseValid = validPulses;
    baseErr = errPulses;
    reset_n = 1'b1;
    @(negedge clk_25m);
    @(negedge clk_25m);
    checkOutput("release.nopulse", 32'((validPulses - baseValid) + (errPulses - baseErr)), 32'd0);
    applyStimulus(16'h0000, 10'h0FC, 0);
    checkBlock("reacqA", 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);

    @(negedge clk_25m);
    checkOutput("never.both", 32'(bothPulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
